// File: rtl/de0qsys_hex_bank.sv
// Avalon-MM seven-segment digit bank with per-digit blink and optional hex decode.
// Hex decoding is built only when DE0QSYS_HEX_BANK_DECODE_EN is defined.
module de0qsys_hex_bank #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [8*NUM_DIGITS-1:0] out_port
);

  localparam int               CNT_W   = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  localparam logic [7:0]       UNLIT   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [7:0]            digit_q [NUM_DIGITS];
  logic [7:0]            digit_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic                  decode_bit;
  logic [7:0]            mask8;
  logic                  wr, ctrl_wr;
  logic                  unused_wd;

`ifdef DE0QSYS_HEX_BANK_DECODE_EN
  logic decode_q, decode_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb decode_bit = decode_q;
`else
  always_comb decode_bit = 1'b0;
`endif

  always_comb begin
    wr        = chipselect & ~write_n;
    ctrl_wr   = wr && (address == 4'd8);
    unused_wd = ^writedata;
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      digit_d[k] = digit_q[k];
      if (wr && address == 4'(k)) digit_d[k] = writedata[7:0];
    end
    mask_d = mask_q;
    if (ctrl_wr) mask_d = writedata[8 +: NUM_DIGITS];
`ifdef DE0QSYS_HEX_BANK_DECODE_EN
    decode_d = decode_q;
    if (ctrl_wr) decode_d = writedata[0];
`endif
    // CTRL write restarts the timer and overrides a coincident wrap toggle
    if (ctrl_wr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      phase_d = phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) digit_q[k] <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
`ifdef DE0QSYS_HEX_BANK_DECODE_EN
      decode_q <= 1'b0;
`endif
    end else begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) digit_q[k] <= digit_d[k];
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
`ifdef DE0QSYS_HEX_BANK_DECODE_EN
      decode_q <= decode_d;
`endif
    end
  end

  always_comb begin
    mask8                   = '0;
    mask8[NUM_DIGITS-1:0]   = mask_q;
    readdata                = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (address == 4'(k)) readdata = {24'b0, digit_q[k]};
    end
    if (address == 4'd8) readdata = {16'b0, mask8, 7'b0, decode_bit};
    if (address == 4'd9) readdata = {31'b0, phase_q};
  end

  always_comb begin
    out_port = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (mask_q[k] && phase_q) begin
        out_port[8*k +: 8] = UNLIT;
`ifdef DE0QSYS_HEX_BANK_DECODE_EN
      end else if (decode_q) begin
        out_port[8*k +: 8] = (ACTIVE_LOW != 0) ? ~{digit_q[k][7], hex7(digit_q[k][3:0])}
                                               :  {digit_q[k][7], hex7(digit_q[k][3:0])};
`endif
      end else begin
        out_port[8*k +: 8] = digit_q[k];
      end
    end
  end

endmodule
